// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32 datapath.
// Generates stage enables, flushes and bubbles. Covers multi-bubble load-use
// stalls, variable-latency data memory with timeout, EX forwarding selects,
// the WB->ID register-file bypass and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned RF_ADDRESS  = 5,
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [RF_ADDRESS-1:0] ex_rs1,
  input  logic [RF_ADDRESS-1:0] ex_rs2,
  input  logic [RF_ADDRESS-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_redirect,
  input  logic [RF_ADDRESS-1:0] mem_rd,
  input  logic [RF_ADDRESS-1:0] wb_rd,
  input  logic                  mem_regwrite,
  input  logic                  wb_regwrite,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StForce} mstate_e;

  localparam logic [1:0]       LuReload = 2'(LU_BUBBLES - 1);
  localparam logic [7:0]       MemTo    = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  mstate_e          mstate_q, mstate_d;
  logic [7:0]       wtimer_q, wtimer_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       mem_stall;
  logic       lu_hit;
  logic       lu_stall;
  logic [7:0] frozen_cnt;

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Hazard detection; the FORCE cycle treats the access as done.
  always_comb begin
    mem_stall = mem_req & ~mem_ready & (mstate_q != StForce);
    lu_hit    = ex_memread & (ex_rd != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    lu_stall  = lu_hit | (lu_cnt_q != 2'd0);
  end

  // Prioritised pipeline control and load-use bubble countdown.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    lu_cnt_d      = lu_cnt_q;
    if (mem_stall) begin
      // Whole front of the pipe freezes; a pending redirect waits in EX.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      lu_cnt_d    = 2'd0;
    end else if (lu_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      if (lu_cnt_q == 2'd0) begin
        lu_cnt_d = LuReload;
      end else begin
        lu_cnt_d = lu_cnt_q - 2'd1;
      end
    end
  end

  // Memory wait FSM; frozen_cnt is the number of frozen cycles including this one.
  always_comb begin
    mstate_d   = mstate_q;
    wtimer_d   = wtimer_q;
    mem_err_d  = mem_err_q;
    frozen_cnt = (mstate_q == StWait) ? wtimer_q + 8'd1 : 8'd1;
    unique case (mstate_q)
      StIdle, StWait: begin
        if (mem_stall) begin
          if (frozen_cnt >= MemTo) begin
            mstate_d  = StForce;
            mem_err_d = 1'b1;
          end else begin
            mstate_d = StWait;
          end
          wtimer_d = frozen_cnt;
        end else begin
          mstate_d = StIdle;
          wtimer_d = 8'd0;
        end
      end
      StForce: begin
        mstate_d = StIdle;
        wtimer_d = 8'd0;
      end
      default: begin
        mstate_d = StIdle;
        wtimer_d = 8'd0;
      end
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (if_id_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // EX forwarding (MEM beats WB, x0 never forwarded) and WB->ID bypass.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
      fwd_a = 2'b10;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
      fwd_a = 2'b01;
    end
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
      fwd_b = 2'b10;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
      fwd_b = 2'b01;
    end
    id_byp_a = wb_regwrite & (wb_rd != '0) & (wb_rd == id_rs1);
    id_byp_b = wb_regwrite & (wb_rd != '0) & (wb_rd == id_rs2);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstate_q    <= StIdle;
      wtimer_q    <= 8'd0;
      lu_cnt_q    <= 2'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      mstate_q    <= mstate_d;
      wtimer_q    <= wtimer_d;
      lu_cnt_q    <= lu_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (LU_BUBBLES=2, MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RfA = 5;
  localparam int unsigned CntW = 4;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] CNorm  = 7'b1111_000;
  localparam logic [6:0] CMem   = 7'b0000_001;
  localparam logic [6:0] CRedir = 7'b1111_110;
  localparam logic [6:0] CLu    = 7'b0011_010;

  logic           clk = 1'b0;
  logic           reset;
  logic [RfA-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic           id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
  logic           mem_regwrite, wb_regwrite, mem_req, mem_ready;
  logic           pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic           if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [1:0]     fwd_a, fwd_b;
  logic           id_byp_a, id_byp_b, mem_err;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [6:0]     ctrl;

  int n_total = 0;
  int n_bad   = 0;

  pipeline_hazard_ctrl #(
    .RF_ADDRESS (RfA),
    .LU_BUBBLES (2),
    .MEM_TIMEOUT(4),
    .CNT_W      (CntW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_redirect  (ex_redirect),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .id_byp_a     (id_byp_a),
    .id_byp_b     (id_byp_b),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_ctrl", 32'(ctrl), 32'(CNorm));
    check_eq("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check_eq("rst_byp", 32'({id_byp_a, id_byp_b}), 32'd0);
    check_eq("rst_err", 32'(mem_err), 32'd0);
    check_eq("rst_scnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_fcnt", 32'(flush_cnt), 32'd0);

    // Load x5 in EX, add x6,x5,x1 in ID: two bubbles.
    step();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    #1;
    check_eq("lu_c0", 32'(ctrl), 32'(CLu));
    check_eq("lu_s0", 32'(stall_cnt), 32'd0);
    step();
    ex_memread = 1'b0; ex_rd = '0;
    #1;
    check_eq("lu_c1", 32'(ctrl), 32'(CLu));
    check_eq("lu_s1", 32'(stall_cnt), 32'd1);
    step();
    wb_regwrite = 1'b1; wb_rd = 5'd5;
    #1;
    check_eq("lu_rel", 32'(ctrl), 32'(CNorm));
    check_eq("lu_s2", 32'(stall_cnt), 32'd2);
    check_eq("byp_a", 32'(id_byp_a), 32'd1);
    check_eq("byp_b", 32'(id_byp_b), 32'd0);
    step();
    ex_rs1 = 5'd5; ex_rs2 = 5'd1;
    #1;
    check_eq("add_fwd_a", 32'(fwd_a), 32'd1);
    check_eq("add_fwd_b", 32'(fwd_b), 32'd0);

    // Forwarding priority and x0 suppression.
    step();
    clear_inputs();
    mem_regwrite = 1'b1; mem_rd = 5'd7; wb_regwrite = 1'b1; wb_rd = 5'd7;
    ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    #1;
    check_eq("fwd_mem_a", 32'(fwd_a), 32'd2);
    check_eq("fwd_mem_b", 32'(fwd_b), 32'd2);
    step();
    mem_rd = '0; wb_rd = '0; ex_rs1 = '0; ex_rs2 = '0;
    #1;
    check_eq("fwd_x0", 32'({fwd_a, fwd_b}), 32'd0);
    step();
    mem_rd = 5'd7; mem_regwrite = 1'b0; wb_rd = 5'd7; ex_rs1 = 5'd3; ex_rs2 = 5'd7;
    #1;
    check_eq("fwd_wb_a", 32'(fwd_a), 32'd0);
    check_eq("fwd_wb_b", 32'(fwd_b), 32'd1);

    // Three-cycle memory wait with a redirect held in EX.
    step();
    clear_inputs();
    mem_req = 1'b1; ex_redirect = 1'b1;
    #1;
    check_eq("mw_c0", 32'(ctrl), 32'(CMem));
    for (int i = 1; i < 3; i++) begin
      step();
      check_eq("mw_cn", 32'(ctrl), 32'(CMem));
    end
    step();
    mem_ready = 1'b1;
    #1;
    check_eq("mw_redir", 32'(ctrl), 32'(CRedir));
    check_eq("mw_err", 32'(mem_err), 32'd0);
    check_eq("mw_scnt", 32'(stall_cnt), 32'd5);
    check_eq("mw_fcnt0", 32'(flush_cnt), 32'd0);
    step();
    clear_inputs();
    #1;
    check_eq("mw_after", 32'(ctrl), 32'(CNorm));
    check_eq("mw_fcnt1", 32'(flush_cnt), 32'd1);

    // Memory never ready: 4 frozen cycles then a FORCE cycle.
    step();
    mem_req = 1'b1;
    #1;
    check_eq("to_c0", 32'(ctrl), 32'(CMem));
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq("to_cn", 32'(ctrl), 32'(CMem));
    end
    step();
    check_eq("to_force", 32'(ctrl), 32'(CNorm));
    check_eq("to_err", 32'(mem_err), 32'd1);
    check_eq("to_scnt", 32'(stall_cnt), 32'd9);
    step();
    mem_req = 1'b0;
    #1;
    check_eq("to_idle", 32'(ctrl), 32'(CNorm));
    check_eq("to_err_sticky", 32'(mem_err), 32'd1);

    // Memory stall in the middle of a load-use countdown holds it.
    step();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    check_eq("fz_lu", 32'(ctrl), 32'(CLu));
    step();
    ex_memread = 1'b0; mem_req = 1'b1;
    #1;
    check_eq("fz_mem", 32'(ctrl), 32'(CMem));
    step();
    mem_ready = 1'b1;
    #1;
    check_eq("fz_resume", 32'(ctrl), 32'(CLu));
    step();
    clear_inputs();
    #1;
    check_eq("fz_done", 32'(ctrl), 32'(CNorm));
    check_eq("fz_scnt", 32'(stall_cnt), 32'd12);

    // Redirect beats a simultaneous load-use hit and clears the countdown.
    step();
    ex_redirect = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    check_eq("rl_ctrl", 32'(ctrl), 32'(CRedir));
    step();
    clear_inputs();
    #1;
    check_eq("rl_next", 32'(ctrl), 32'(CNorm));
    check_eq("rl_fcnt", 32'(flush_cnt), 32'd2);
    check_eq("rl_scnt", 32'(stall_cnt), 32'd12);

    // Continuous load-use hit drives stall_cnt into saturation.
    step();
    ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    repeat (5) step();
    check_eq("sat_scnt", 32'(stall_cnt), 32'd15);
    step();
    check_eq("sat_hold", 32'(stall_cnt), 32'd15);
    clear_inputs();
    repeat (2) step();

    // Reset in the middle of a memory wait acts before the next edge.
    mem_req = 1'b1;
    repeat (2) step();
    check_eq("pre_rst_err", 32'(mem_err), 32'd1);
    check_eq("pre_rst_ctrl", 32'(ctrl), 32'(CMem));
    #2;
    reset = 1'b1;
    mem_req = 1'b0;
    #1;
    check_eq("arst_scnt", 32'(stall_cnt), 32'd0);
    check_eq("arst_fcnt", 32'(flush_cnt), 32'd0);
    check_eq("arst_err", 32'(mem_err), 32'd0);
    check_eq("arst_ctrl", 32'(ctrl), 32'(CNorm));
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("post_rst", 32'(ctrl), 32'(CNorm));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
